// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-master (instruction fetch / load-store) to one-slave
//             arbiter for the unified memory bus. Grants one master at a
//             time, muxes its request onto the slave channel and routes
//             ready/rdata back only to the granted master.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int D_PRIORITY = 1,
   parameter int AW         = 32,
   parameter int DW         = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   // instruction fetch master
   input  logic            i_valid,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ready,
   output logic [DW-1:0]   i_rdata,
   // load/store master
   input  logic            d_valid,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wstrb,
   output logic            d_ready,
   output logic [DW-1:0]   d_rdata,
   // memory slave
   output logic            m_valid,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_wstrb,
   input  logic            m_ready,
   input  logic [DW-1:0]   m_rdata,
   // current owner {D,I}, 00 = idle
   output logic [1:0]      grant
);

   // State encoding doubles as the grant vector, so grant is simply a
   // registered copy of the state.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } state_t;

   state_t state;
   logic   xfer_done;

   // Transfer completion: the granted request meets the slave's ready.
   always_comb begin
      xfer_done = m_valid && m_ready;
   end

   // Arbitration FSM. On completion the other master is considered first,
   // which makes grants alternate under continuous dual requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid && d_valid) begin
                  if (D_PRIORITY != 0) begin
                     state <= GNT_D;
                     grant <= GNT_D;
                  end else begin
                     state <= GNT_I;
                     grant <= GNT_I;
                  end
               end else if (d_valid) begin
                  state <= GNT_D;
                  grant <= GNT_D;
               end else if (i_valid) begin
                  state <= GNT_I;
                  grant <= GNT_I;
               end
            end
            GNT_I: begin
               if (xfer_done) begin
                  if (d_valid) begin
                     state <= GNT_D;
                     grant <= GNT_D;
                  end else begin
                     state <= IDLE;
                     grant <= IDLE;
                  end
               end
            end
            GNT_D: begin
               if (xfer_done) begin
                  if (i_valid) begin
                     state <= GNT_I;
                     grant <= GNT_I;
                  end else begin
                     state <= IDLE;
                     grant <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               grant <= IDLE;
            end
         endcase
      end
   end

   // Request mux toward the slave and response steering back to the owner.
   // Fetches are read-only, so write data/strobes are forced to zero in GNT_I.
   always_comb begin
      m_valid = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      i_ready = 1'b0;
      i_rdata = '0;
      d_ready = 1'b0;
      d_rdata = '0;
      case (state)
         GNT_I: begin
            m_valid = i_valid;
            m_addr  = i_addr;
            i_ready = m_ready;
            i_rdata = m_rdata;
         end
         GNT_D: begin
            m_valid = d_valid;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_wstrb = d_wstrb;
            d_ready = m_ready;
            d_rdata = m_rdata;
         end
         default: begin
            m_valid = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
